// File: rtl/alu_pkg.sv
// Shared op codes, op classification helpers and FSM state type for the ALU family.
// Encodings match the original single-cycle ALU so decode needs no change.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SLL  = 5'b00001;
  localparam logic [4:0] OP_SLT  = 5'b00010;
  localparam logic [4:0] OP_SLTU = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_SUB  = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01101;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BNE  = 5'b10001;
  localparam logic [4:0] OP_BLT  = 5'b10100;
  localparam logic [4:0] OP_BGE  = 5'b10101;
  localparam logic [4:0] OP_BLTU = 5'b10110;
  localparam logic [4:0] OP_BGEU = 5'b10111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_mc_state_t;

  function automatic logic alu_op_valid(input logic [4:0] op);
    logic v;
    v = 1'b0;
    case (op)
      OP_ADD, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_OR,  OP_AND,
      OP_SUB, OP_SRA, OP_BEQ, OP_BNE,
      OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: v = 1'b1;
      default:                          v = 1'b0;
    endcase
    return v;
  endfunction

  function automatic logic alu_op_is_shift(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational non-shift datapath: add/sub, logic ops, set-less-than and branch compares.
// Zero latency; shift and invalid codes yield zero and are handled by the caller.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (i_a == i_b);
  assign w_lt_s = ($signed(i_a) < $signed(i_b));
  assign w_lt_u = (i_a < i_b);

  // Compare results are single bits zero-extended to the datapath width.
  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:          o_result = i_a + i_b;
      OP_SUB:          o_result = i_a - i_b;
      OP_XOR:          o_result = i_a ^ i_b;
      OP_OR:           o_result = i_a | i_b;
      OP_AND:          o_result = i_a & i_b;
      OP_SLT, OP_BLT:  o_result = {{(WIDTH-1){1'b0}}, w_lt_s};
      OP_SLTU, OP_BLTU: o_result = {{(WIDTH-1){1'b0}}, w_lt_u};
      OP_BGE:          o_result = {{(WIDTH-1){1'b0}}, ~w_lt_s};
      OP_BGEU:         o_result = {{(WIDTH-1){1'b0}}, ~w_lt_u};
      OP_BEQ:          o_result = {{(WIDTH-1){1'b0}}, w_eq};
      OP_BNE:          o_result = {{(WIDTH-1){1'b0}}, ~w_eq};
      default:         o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: non-shift ops complete in one cycle, shifts iterate SHIFT_STEP bits per cycle.
// Accepts only in IDLE; result is held in DONE until out_ready, then one idle cycle before the next op.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             fault
);

  localparam int           SHW  = $clog2(WIDTH);
  localparam logic [SHW:0] STEP = (SHW+1)'(SHIFT_STEP);

  alu_mc_state_t    r_state;
  logic [4:0]       r_op;
  logic             r_sign;
  logic [SHW-1:0]   r_rem;
  logic [WIDTH-1:0] r_out;
  logic             r_fault;

  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_comb;
  logic [SHW:0]     w_rem_ext;
  logic [SHW:0]     w_step;
  logic [SHW:0]     w_rem_next;
  logic [WIDTH-1:0] w_fill_mask;
  logic [WIDTH-1:0] w_shifted;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .i_op    (op),
    .i_a     (in_a),
    .i_b     (in_b),
    .o_result(w_comb)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign fault     = r_fault;

  assign w_accept = in_valid & in_ready;
  assign w_shamt  = in_b[SHW-1:0];

  // Last iteration may move fewer than SHIFT_STEP bits so the total equals shamt exactly.
  assign w_rem_ext   = {1'b0, r_rem};
  assign w_step      = (w_rem_ext < STEP) ? w_rem_ext : STEP;
  assign w_rem_next  = w_rem_ext - w_step;
  assign w_fill_mask = ~({WIDTH{1'b1}} >> w_step);

  always_comb begin
    w_shifted = r_out;
    case (r_op)
      OP_SLL:  w_shifted = r_out << w_step;
      OP_SRL:  w_shifted = r_out >> w_step;
      OP_SRA:  w_shifted = (r_out >> w_step) | (w_fill_mask & {WIDTH{r_sign}});
      default: w_shifted = r_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_op    <= '0;
      r_sign  <= 1'b0;
      r_rem   <= '0;
      r_out   <= '0;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= op;
            r_sign <= in_a[WIDTH-1];
            r_rem  <= w_shamt;
            if (!alu_op_valid(op)) begin
              r_out   <= '0;
              r_fault <= 1'b1;
              r_state <= DONE;
            end else if (alu_op_is_shift(op)) begin
              r_out   <= in_a;
              r_fault <= 1'b0;
              r_state <= (w_shamt == '0) ? DONE : SHIFT;
            end else begin
              r_out   <= w_comb;
              r_fault <= 1'b0;
              r_state <= DONE;
            end
          end
        end
        SHIFT: begin
          r_out <= w_shifted;
          r_rem <= w_rem_next[SHW-1:0];
          if (w_rem_next == '0) begin
            r_fault <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
